// File: rtl/count_capture_fifo.sv
// count_capture_fifo: show-ahead FIFO buffering counter samples strobed by result, with drop statistics.
// Define CAPTURE_DEDUP_EN to suppress captures that repeat the last processed count value.
module count_capture_fifo #(
  parameter int CNT_W  = 6,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CNT_W-1:0]  count,
  input  logic              result,
  input  logic              out_ready,
  input  logic              clear_ovf,
  output logic              out_valid,
  output logic [CNT_W-1:0]  out_data,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);
  logic [CNT_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              push_req, pop, push, drop;
`ifdef CAPTURE_DEDUP_EN
  logic [CNT_W-1:0]  last_val;
  logic              last_vld;
  assign push_req = result && !(last_vld && count == last_val);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      last_val <= '0;
      last_vld <= 1'b0;
    end else if (push_req) begin
      last_val <= count;
      last_vld <= 1'b1;
    end
`else
  assign push_req = result;
`endif
  assign full      = level == (ADDR_W+1)'(DEPTH);
  assign empty     = level == '0;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= count;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) rd_ptr <= rd_ptr + ADDR_W'(1);
      level <= (push && !pop) ? level + (ADDR_W+1)'(1) :
               (pop && !push) ? level - (ADDR_W+1)'(1) : level;
      // a drop in the same cycle as clear_ovf restarts the statistics at one
      overflow <= drop ? 1'b1 : clear_ovf ? 1'b0 : overflow;
      drop_cnt <= drop ? (clear_ovf ? 8'd1 : (drop_cnt == 8'hff ? drop_cnt : drop_cnt + 8'd1)) :
                  clear_ovf ? 8'd0 : drop_cnt;
    end
endmodule

// File: tb/tb_count_capture_fifo.sv
// tb_count_capture_fifo: scoreboard bench for count_capture_fifo (dedup scenario under CAPTURE_DEDUP_EN).
module tb_count_capture_fifo;
  logic       clock = 0, reset = 1;
  logic [5:0] count = 0;
  logic       result = 0, out_ready = 0, clear_ovf = 0;
  logic       out_valid, full, empty, overflow;
  logic [5:0] out_data;
  logic [3:0] level;
  logic [7:0] drop_cnt;
  int checks = 0, failures = 0;
  logic [5:0] exp_q[$];
  logic       m_ovf = 0;
  logic [7:0] m_drop = 0;
  logic [5:0] m_last = 0;
  logic       m_lvld = 0;
  logic [5:0] last_pop = 0;
  int         pops = 0;

  count_capture_fifo dut (
    .clock(clock), .reset(reset), .count(count), .result(result),
    .out_ready(out_ready), .clear_ovf(clear_ovf), .out_valid(out_valid),
    .out_data(out_data), .level(level), .full(full), .empty(empty),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  task automatic cyc(input logic r, input logic [5:0] c, input logic rdy, input logic clr);
    logic req, mpop, mfull, mdrop;
    result = r; count = c; out_ready = rdy; clear_ovf = clr;
    #1;
    checks++;
    if (out_valid !== (exp_q.size() != 0)) begin
      failures++;
      $display("FAIL out_valid got=%b exp=%b", out_valid, exp_q.size() != 0);
    end
    mpop = rdy && exp_q.size() != 0;
    if (mpop) begin
      checks++;
      if (out_data !== exp_q[0]) begin
        failures++;
        $display("FAIL pop_data got=%h exp=%h", out_data, exp_q[0]);
      end
      last_pop = exp_q.pop_front();
      pops++;
    end
    req = r;
`ifdef CAPTURE_DEDUP_EN
    if (r && m_lvld && c == m_last) req = 0;
    if (req) begin m_last = c; m_lvld = 1; end
`endif
    mfull = (exp_q.size() + (mpop ? 1 : 0)) == 8;
    mdrop = req && mfull && !mpop;
    if (req && !mdrop) exp_q.push_back(c);
    m_ovf  = mdrop ? 1'b1 : clr ? 1'b0 : m_ovf;
    m_drop = mdrop ? (clr ? 8'd1 : (m_drop == 8'hff ? m_drop : m_drop + 8'd1)) : clr ? 8'd0 : m_drop;
    @(posedge clock); #1;
    result = 0; out_ready = 0; clear_ovf = 0;
    checks++;
    if (level !== 4'(exp_q.size()) || full !== (exp_q.size() == 8) || empty !== (exp_q.size() == 0)) begin
      failures++;
      $display("FAIL level got=%0d/f%b/e%b exp=%0d", level, full, empty, exp_q.size());
    end
    checks++;
    if (overflow !== m_ovf || drop_cnt !== m_drop) begin
      failures++;
      $display("FAIL stats got=ovf%b/%0d exp=ovf%b/%0d", overflow, drop_cnt, m_ovf, m_drop);
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #2;
    reset = 1;
    exp_q.delete(); m_ovf = 0; m_drop = 0; m_lvld = 0; m_last = 0;
    @(posedge clock); #2;
    reset = 0;
    @(posedge clock); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc(0, 0, 1, 0);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (level !== 0 || empty !== 1 || full !== 0 || out_valid !== 0 || overflow !== 0 || drop_cnt !== 0) begin
      failures++;
      $display("FAIL reset_state got=lvl%0d e%b f%b v%b o%b d%0d", level, empty, full, out_valid, overflow, drop_cnt);
    end
    reset = 0;
    @(posedge clock); #1;
  endtask

  task automatic test_single();
    cyc(1, 6'h15, 0, 0);
    checks++;
    if (out_valid !== 1 || out_data !== 6'h15 || level !== 1) begin
      failures++;
      $display("FAIL single got=v%b d%h l%0d exp=v1 d15 l1", out_valid, out_data, level);
    end
    cyc(0, 0, 1, 0);
    checks++;
    if (empty !== 1) begin failures++; $display("FAIL single_empty got=%b exp=1", empty); end
    cyc(0, 0, 1, 0);
  endtask

  task automatic test_fill_drop();
    for (int i = 1; i <= 8; i++) cyc(1, 6'(i), 0, 0);
    checks++;
    if (full !== 1 || level !== 8) begin failures++; $display("FAIL fill got=f%b l%0d exp=f1 l8", full, level); end
    cyc(1, 6'd9, 0, 0);
    checks++;
    if (overflow !== 1 || drop_cnt !== 1) begin failures++; $display("FAIL drop9 got=o%b d%0d exp=o1 d1", overflow, drop_cnt); end
    pops = 0;
    drain();
    checks++;
    if (pops !== 8 || last_pop !== 6'd8) begin failures++; $display("FAIL drain got=n%0d last%0d exp=n8 last8", pops, last_pop); end
    cyc(0, 0, 0, 1);
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < 8; i++) cyc(1, 6'(16 + i), 0, 0);
    cyc(1, 6'h2a, 1, 0);
    checks++;
    if (level !== 8 || drop_cnt !== 0 || overflow !== 0) begin
      failures++;
      $display("FAIL pushpop got=l%0d d%0d o%b exp=l8 d0 o0", level, drop_cnt, overflow);
    end
    drain();
    checks++;
    if (last_pop !== 6'h2a) begin failures++; $display("FAIL pushpop_last got=%h exp=2a", last_pop); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 8; i++) cyc(1, 6'(i), 0, 0);
    for (int i = 0; i < 300; i++) cyc(1, 6'(i + 8), 0, 0);
    checks++;
    if (drop_cnt !== 8'd255 || overflow !== 1) begin failures++; $display("FAIL saturate got=%0d exp=255", drop_cnt); end
    cyc(1, 6'h3f, 0, 1);
    checks++;
    if (overflow !== 1 || drop_cnt !== 1) begin failures++; $display("FAIL clr_drop got=o%b d%0d exp=o1 d1", overflow, drop_cnt); end
    drain();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) cyc(1, 6'(i * 3 + 1), 0, 0);
    #2;
    reset = 1;
    #1;
    checks++;
    if (empty !== 1 || level !== 0 || out_valid !== 0) begin
      failures++;
      $display("FAIL async_reset got=e%b l%0d v%b exp=e1 l0 v0", empty, level, out_valid);
    end
    exp_q.delete(); m_ovf = 0; m_drop = 0; m_lvld = 0; m_last = 0;
    @(posedge clock); #2;
    reset = 0;
    @(posedge clock); #1;
    cyc(1, 6'h07, 1, 0);
    cyc(0, 0, 1, 0);
  endtask

`ifdef CAPTURE_DEDUP_EN
  task automatic test_dedup();
    logic [5:0] seq [6];
    seq = '{6'd3, 6'd3, 6'd3, 6'd4, 6'd4, 6'd3};
    do_reset();
    foreach (seq[i]) cyc(1, seq[i], 0, 0);
    checks++;
    if (level !== 3 || drop_cnt !== 0) begin failures++; $display("FAIL dedup got=l%0d d%0d exp=l3 d0", level, drop_cnt); end
    pops = 0;
    drain();
    checks++;
    if (pops !== 3 || last_pop !== 6'd3) begin failures++; $display("FAIL dedup_drain got=n%0d last%0d exp=n3 last3", pops, last_pop); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill_drop();
    test_full_pushpop();
    test_saturate();
    test_async_reset();
`ifdef CAPTURE_DEDUP_EN
    test_dedup();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/count_capture_fifo.md
Name: count_capture_fifo

Overview:
- Downstream consumer of the BinaryCounter stage.
- Samples the counter's `count` bus each cycle that `result` is high and buffers the samples in a small show-ahead FIFO.
- Drains through a valid/ready interface to the next stage (logger/checker).
- Reports occupancy, overflow and dropped-sample statistics.

Parameters:
- CNT_W, 6, width of the captured count value; matches BinaryCounter `count`.
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- ADDR_W, 3, log2(DEPTH); pointer width.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- count  input  CNT_W  counter value from BinaryCounter.
- result  input  1  capture strobe from BinaryCounter.
- out_ready  input  1  downstream accepts `out_data` this cycle.
- clear_ovf  input  1  clears `overflow` and `drop_cnt`.
- out_valid  output  1  `out_data` holds a valid entry.
- out_data  output  CNT_W  oldest buffered sample (show-ahead).
- level  output  ADDR_W+1  current occupancy, 0..DEPTH.
- full  output  1  `level` == DEPTH.
- empty  output  1  `level` == 0.
- overflow  output  1  sticky flag: a sample was dropped.
- drop_cnt  output  8  dropped-sample count, saturating.

Behaviour:
- Reset:
  - Reset is asynchronous and active-high; the clock port is `clock` and the reset port is `reset`.
  - While `reset` is high: pointers=0, `level`=0, `empty`=1, `full`=0, `out_valid`=0, `overflow`=0, `drop_cnt`=0.
  - `out_data` is don't-care while `empty`; RTL drives mem[rd_ptr], and memory is not reset.
  - Reset asserted mid-operation discards all entries immediately; no partial state survives.
- Push request:
  - push_req = `result` sampled at a rising edge.
  - `count` is written to mem[wr_ptr] at that edge.
- Pop:
  - pop = `out_valid` && `out_ready` at a rising edge.
  - `rd_ptr` advances at that edge.
  - `out_ready` while empty is ignored.
- Push acceptance: push = push_req && (!full || pop).
  - A push while full is accepted if a pop happens in the same cycle; `level` is unchanged in that case.
- Level update:
  - push only: +1.
  - pop only: -1.
  - both, or neither: unchanged.
- Latency:
  - A sample captured at edge N appears on `out_data` with `out_valid`=1 after edge N when the FIFO was empty (1 cycle).
  - Otherwise the sample is presented after all older entries have popped.
- Ordering: strict FIFO order.
- Pointers: wrap modulo DEPTH; full/empty are derived from `level`, not from pointer compare.
- `out_valid` = !empty; `out_data` = mem[rd_ptr], combinational from registered pointer/memory.
- Drop rule: push_req && full && !pop discards the sample and, at that edge:
  - sets `overflow`;
  - increments `drop_cnt`, saturating at 255.
- `clear_ovf` at an edge clears `overflow` and `drop_cnt` to 0.
  - If a drop occurs in the same cycle, the drop wins: `overflow`=1, `drop_cnt`=1.
- `count` value is captured unmodified; no arithmetic on data.
- Control state: none beyond the FIFO. The effective states are EMPTY (`level`=0), PARTIAL, and FULL (`level`=DEPTH), selected purely by `level`.

Optional Feature:
- Macro: CAPTURE_DEDUP_EN.
- When defined:
  - A `last_val` register (CNT_W) and a `last_vld` flag are added; both reset to 0.
  - A push_req whose `count` equals `last_val` while `last_vld`=1 is suppressed.
  - A suppressed request is not written, is not a drop, and does not touch `overflow` or `drop_cnt`.
  - Every push_req that is not suppressed updates `last_val`=`count` and `last_vld`=1, including requests dropped because the FIFO is full.
- When undefined: every push_req is processed as above; `last_val` and `last_vld` do not exist.

Test Plan:
- Reset, then `result`=1 for one cycle with `count`=6'h15 -> next cycle `out_valid`=1, `out_data`=6'h15, `level`=1; `out_ready`=1 one cycle -> `empty`=1.
- Push 8 samples 1..8 with `out_ready`=0 -> `full`=1, `level`=8; a 9th push (`count`=9) -> `overflow`=1, `drop_cnt`=1; drain -> outputs 1..8 in order and 9 is absent.
- Hold full, assert `result` (`count`=6'h2A) and `out_ready` in the same cycle -> `level` stays 8, no drop, and 6'h2A is the last entry out.
- 300 pushes with the FIFO full and `out_ready`=0 -> `drop_cnt`=255 (saturated); `clear_ovf` together with a further drop -> `overflow`=1, `drop_cnt`=1.
- Fill with 5 entries, assert `reset` asynchronously between edges -> `empty`=1, `level`=0, `out_valid`=0 immediately, without waiting for a clock edge.
- CAPTURE_DEDUP_EN defined: push_req sequence 3,3,3,4,4,3 -> FIFO receives 3,4,3 and `drop_cnt`=0.
